image_pair_buffer: RTL and testbench

IMAGE_PAIR_BUFFER -- requirements
Module: image_pair_buffer

---
 rtl/image_pair_buffer.sv | 160 ++++++++++++++++
 tb/tb_image_pair_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pair_buffer.sv
// rtl/image_pair_buffer.sv - ping-pong frame store emitting (previous, current) pixel pairs
//
// Captures raster-order frames into one of two banks. Once two frames have
// been captured, the frame just completed is streamed out pixel by pixel
// alongside the co-located pixel of the frame before it.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_data    incoming pixel (raster order)
//   in_valid   in_data valid this cycle
//   in_sof     marks in_data as pixel 0 of a frame
//   in_ready   block accepts input (low while streaming output)
//   out_prev   pixel of the previous frame at the current read address
//   out_curr   pixel of the most recent frame at the same address
//   out_valid  output pair valid
//   out_ready  downstream accepts the pair
//   out_sof    pair 0 of the frame
//   out_eof    last pair of the frame
//   frame_cnt  completed input frames, wraps at 2^16
//   err_sof    one-cycle pulse when in_sof arrives mid-frame
module image_pair_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_prev,
    output logic [DATA_WIDTH-1:0] out_curr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [15:0]           frame_cnt,
    output logic                  err_sof
);

    localparam int FRAME_SIZE = IMG_W * IMG_H;
    // A one-pixel frame still needs a one-bit address register.
    localparam int ADDR_WIDTH = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_SIZE - 1);

    typedef enum logic [1:0] {IDLE, STORE, OUTPUT} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    wr_bank;
    logic                    have_prev;
    logic                    primed;

    logic [DATA_WIDTH-1:0]   mem0 [FRAME_SIZE];
    logic [DATA_WIDTH-1:0]   mem1 [FRAME_SIZE];

    logic                    wr_en;
    logic                    wr_last;
    logic [ADDR_WIDTH-1:0]   wr_addr;

    // in_ready is low in OUTPUT, so a write can only happen in IDLE or STORE.
    // Any pixel carrying in_sof lands at address 0, which also covers restarts.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = in_sof ? '0 : addr;
        if (in_valid && in_ready)
            wr_en = (state == STORE) || (state == IDLE && in_sof);
        wr_last = (wr_addr == LAST_ADDR);
    end

    // Frame store is never reset; stale contents are harmless because
    // have_prev gates any use of the other bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank)
                mem1[wr_addr] <= in_data;
            else
                mem0[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            rd_addr   <= '0;
            wr_bank   <= 1'b0;
            have_prev <= 1'b0;
            primed    <= 1'b0;
            frame_cnt <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_prev  <= '0;
            out_curr  <= '0;
            err_sof   <= 1'b0;
        end else begin
            err_sof <= 1'b0;
            case (state)
                IDLE, STORE: begin
                    if (wr_en) begin
                        if (state == STORE && in_sof && addr != '0)
                            err_sof <= 1'b1;
                        if (wr_last) begin
                            wr_bank   <= ~wr_bank;
                            frame_cnt <= frame_cnt + 16'd1;
                            addr      <= '0;
                            rd_addr   <= '0;
                            primed    <= 1'b0;
                            have_prev <= 1'b1;
                            if (have_prev) begin
                                state    <= OUTPUT;
                                in_ready <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            addr  <= wr_addr + ADDR_WIDTH'(1);
                            state <= STORE;
                        end
                    end
                end
                OUTPUT: begin
                    // One spare cycle after the last write lets the first read
                    // land two cycles after that write.
                    if (!primed) begin
                        primed <= 1'b1;
                    end else if (out_valid && out_ready && out_eof) begin
                        out_valid <= 1'b0;
                        out_sof   <= 1'b0;
                        out_eof   <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                    end else if (!out_valid || out_ready) begin
                        // Output registers double as the RAM read registers;
                        // rd_addr only advances on a load, so a stall holds both.
                        // wr_bank has already toggled: the completed frame is
                        // in the bank not selected by wr_bank.
                        out_curr  <= wr_bank ? mem0[rd_addr] : mem1[rd_addr];
                        out_prev  <= wr_bank ? mem1[rd_addr] : mem0[rd_addr];
                        out_valid <= 1'b1;
                        out_sof   <= (rd_addr == '0);
                        out_eof   <= (rd_addr == LAST_ADDR);
                        if (rd_addr != LAST_ADDR)
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_pair_buffer.sv
// tb/tb_image_pair_buffer.sv - randomized bench for image_pair_buffer against a frame-level model
module tb_image_pair_buffer;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 2;
    localparam int FS = IW * IH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_prev;
    logic [DW-1:0] out_curr;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sof;
    logic          out_eof;
    logic [15:0]   frame_cnt;
    logic          err_sof;

    image_pair_buffer #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .out_prev(out_prev), .out_curr(out_curr), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .frame_cnt(frame_cnt), .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: pixels of the frame being assembled, the last
    // complete frame, and the queue of pairs still owed downstream.
    logic [DW-1:0]   asm_q[$];
    logic [DW-1:0]   last_frame[$];
    logic [2*DW+1:0] exp_q[$];
    logic [2*DW+1:0] held;
    logic [2*DW+1:0] cur;
    bit              have_prev = 0;
    bit              outputting = 0;
    bit              err_exp = 0;
    bit              waiting_first = 0;
    bit              held_valid = 0;
    bit              xfer;
    int              fcnt = 0;
    int              cyc = 0;
    int              done_cyc = 0;
    int              pairs_acc = 0;
    int              ready_mode = 0;
    int              tcnt = 0;

    task automatic model_reset();
        asm_q.delete();
        last_frame.delete();
        exp_q.delete();
        have_prev = 0;
        outputting = 0;
        err_exp = 0;
        waiting_first = 0;
        held_valid = 0;
        fcnt = 0;
    endtask

    // Sample at the falling edge: inputs and outputs are settled for the
    // next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            xfer = in_valid && !outputting;
            check("in_ready", {31'b0, in_ready}, {31'b0, !outputting});
            check("err_sof", {31'b0, err_sof}, {31'b0, err_exp});
            err_exp = 0;
            check("frame_cnt", {16'b0, frame_cnt}, {16'b0, fcnt[15:0]});
            cur = {out_sof, out_eof, out_prev, out_curr};
            if (held_valid)
                check("stall_hold", {13'b0, out_valid, cur}, {13'b0, 1'b1, held});
            if (out_valid) begin
                if (waiting_first) begin
                    // Two cycles after the final write edge, i.e. the third
                    // falling edge after the one that saw the final pixel.
                    check("first_latency", cyc - done_cyc, 3);
                    waiting_first = 0;
                end
                if (exp_q.size() == 0)
                    check("unexpected_valid", {31'b0, out_valid}, 0);
                else
                    check("pair", {14'b0, cur}, {14'b0, exp_q[0]});
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    pairs_acc++;
                    if (exp_q.size() == 0) outputting = 0;
                    held_valid = 0;
                end else begin
                    held_valid = 1;
                    held = cur;
                end
            end else begin
                held_valid = 0;
            end
            if (xfer) begin
                if (in_sof) begin
                    if (asm_q.size() != 0) err_exp = 1;
                    asm_q.delete();
                    asm_q.push_back(in_data);
                end else if (asm_q.size() != 0) begin
                    asm_q.push_back(in_data);
                end
                if (asm_q.size() == FS) begin
                    fcnt++;
                    if (have_prev) begin
                        for (int i = 0; i < FS; i++)
                            exp_q.push_back({(i == 0), (i == FS - 1), last_frame[i], asm_q[i]});
                        outputting = 1;
                        waiting_first = 1;
                        done_cyc = cyc;
                    end
                    last_frame = asm_q;
                    have_prev = 1;
                    asm_q.delete();
                end
            end
        end
    end

    logic [3:0] toggle_pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin out_ready = toggle_pat[tcnt % 4]; tcnt++; end
            2: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // All driver tasks start and end at rising edge + 1.
    task automatic send(input logic [DW-1:0] d, input logic s);
        bit ok;
        ok = 0;
        in_data = d;
        in_sof = s;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("send_timeout", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FS; i++) send(base + DW'(i), (i == 0));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!outputting && exp_q.size() == 0) begin ok = 1; break; end
        end
        check("drain_done", exp_q.size(), 0);
        @(posedge clk); #1;
        check("drain_valid_low", {31'b0, out_valid}, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 0);
        check({tag, "_flags"}, {29'b0, out_sof, out_eof, err_sof}, 0);
        check({tag, "_data"}, {16'b0, out_prev, out_curr}, 0);
        check({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Pixels without in_sof in IDLE are discarded.
        for (int i = 0; i < 10; i++) send(DW'($urandom), 1'b0);
        check("idle_frame_cnt", {16'b0, frame_cnt}, 0);

        // Frames A, B, C with out_ready held high.
        send_frame(8'h00);
        send_frame(8'h10);
        wait_drain();
        check("frame_cnt_ab", {16'b0, frame_cnt}, 2);
        send_frame(8'h20);
        wait_drain();
        check("frame_cnt_abc", {16'b0, frame_cnt}, 3);

        // out_ready toggles 1,0,0,1.
        ready_mode = 1;
        send_frame(8'h30);
        wait_drain();
        ready_mode = 0;

        // Restart at pixel 5: pixels 0..4, then a new sof and 7 more.
        for (int i = 0; i < 5; i++) send(8'h40 + DW'(i), (i == 0));
        for (int i = 0; i < FS; i++) send(8'h50 + DW'(i), (i == 0));
        wait_drain();
        check("frame_cnt_restart", {16'b0, frame_cnt}, 5);

        // Reset in the middle of the output stream.
        pairs_acc = 0;
        send_frame(8'h60);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pairs_acc >= 3) break;
        end
        check("mid_pairs_seen", pairs_acc >= 3, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_reset();
        #1 check_reset_state("mid");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // First frame after reset produces no output.
        send_frame(8'h70);
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_frame_cnt", {16'b0, frame_cnt}, 1);
        check("post_reset_no_valid", {31'b0, out_valid}, 0);

        // Randomized frames, gaps, restarts and backpressure.
        ready_mode = 2;
        for (int f = 0; f < 25; f++) begin
            int rs;
            rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FS - 1) : 0;
            for (int i = 0; i < rs; i++) send(DW'($urandom), (i == 0));
            for (int i = 0; i < FS; i++) begin
                send(DW'($urandom), (i == 0));
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
